// File: rtl/seq_c2_bcd_display_decoder.sv
// Signed two's-complement word to BCD digits, seven-segment patterns and active-low sign.
// Iterative double-dabble runs one bit per clock, so the result lands DW_IN+1 cycles after acceptance.
`timescale 1ns/1ps
module seq_c2_bcd_display_decoder #(
    parameter int DW_IN         = 8,
    parameter int DIGITS        = 3,
    parameter int SEGMENT_WIDTH = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DW_IN-1:0]                number,
    input  logic                            blank_lz,
    output logic                            done,
    output logic                            sign_n,
    output logic [4*DIGITS-1:0]             bcd,
    output logic [SEGMENT_WIDTH*DIGITS-1:0] segments
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DW_IN + 1);

    function automatic int min_digits(input int w);
        logic [127:0] v;
        int           n;
        v = 128'd1 << (w - 1);
        n = 0;
        while (v != 0) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    generate
        if (DW_IN < 2 || DW_IN > 128) begin : g_bad_dw
            $error("DW_IN must be in 2..128");
        end
        if (DIGITS < min_digits(DW_IN)) begin : g_bad_digits
            $error("DIGITS too small to hold 2^(DW_IN-1)");
        end
        if (SEGMENT_WIDTH != 7) begin : g_bad_seg
            $error("SEGMENT_WIDTH must be 7");
        end
    endgenerate

    function automatic logic [SEGMENT_WIDTH-1:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                            state_q;
    logic [DW_IN-1:0]                  mag_q;
    logic [BW-1:0]                     bcd_sh_q;
    logic [CW-1:0]                     cnt_q;
    logic                              neg_q;
    logic                              blank_q;
    logic                              mag_nz_q;
    logic                              done_q;
    logic                              sign_n_q;
    logic [BW-1:0]                     bcd_q;
    logic [SEGMENT_WIDTH*DIGITS-1:0]   seg_q;

    logic [DW_IN-1:0]                  mag_abs_d;
    logic [BW-1:0]                     adj_d;
    logic [BW-1:0]                     bcd_sh_d;
    logic [SEGMENT_WIDTH*DIGITS-1:0]   seg_d;
    logic                              seen_nz;

    always_comb begin
        mag_abs_d = number[DW_IN-1] ? (~number + 1'b1) : number;

        adj_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj_d[4*k +: 4] = (bcd_sh_q[4*k +: 4] >= 4'd5) ? bcd_sh_q[4*k +: 4] + 4'd3
                                                            : bcd_sh_q[4*k +: 4];
        end
        bcd_sh_d = {adj_d[BW-2:0], mag_q[DW_IN-1]};

        // Scan from the top digit down; zeros stay blank until the first non-zero or the units digit.
        seg_d   = '0;
        seen_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (bcd_sh_q[4*k +: 4] != 4'd0 || k == 0) begin
                seen_nz = 1'b1;
            end
            seg_d[SEGMENT_WIDTH*k +: SEGMENT_WIDTH] =
                (blank_q && !seen_nz) ? '0 : seg_decode(bcd_sh_q[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            bcd_sh_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            blank_q  <= 1'b0;
            mag_nz_q <= 1'b0;
            done_q   <= 1'b0;
            sign_n_q <= 1'b1;
            bcd_q    <= '0;
            seg_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        neg_q    <= number[DW_IN-1];
                        blank_q  <= blank_lz;
                        mag_nz_q <= |number;
                        mag_q    <= mag_abs_d;
                        bcd_sh_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sh_q <= bcd_sh_d;
                    mag_q    <= {mag_q[DW_IN-2:0], 1'b0};
                    if (cnt_q == CW'(DW_IN - 1)) begin
                        state_q <= LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LOAD: begin
                    bcd_q    <= bcd_sh_q;
                    seg_q    <= seg_d;
                    sign_n_q <= ~(neg_q & mag_nz_q);
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE);
    assign done     = done_q;
    assign sign_n   = sign_n_q;
    assign bcd      = bcd_q;
    assign segments = seg_q;
endmodule

// File: tb/tb_seq_c2_bcd_display_decoder.sv
// Directed bench for the sequential BCD display decoder (8-bit default and 16-bit/5-digit instances).
`timescale 1ns/1ps
module tb_seq_c2_bcd_display_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic [7:0]  number = '0;
    logic        blank_lz = 1'b0;
    logic        in_ready, done, sign_n;
    logic [11:0] bcd;
    logic [20:0] segments;

    logic        in_valid2 = 1'b0;
    logic [15:0] number2 = '0;
    logic        blank2 = 1'b0;
    logic        in_ready2, done2, sign_n2;
    logic [19:0] bcd2;
    logic [34:0] segments2;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_c2_bcd_display_decoder u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .number(number), .blank_lz(blank_lz), .done(done), .sign_n(sign_n),
        .bcd(bcd), .segments(segments)
    );

    seq_c2_bcd_display_decoder #(.DW_IN(16), .DIGITS(5), .SEGMENT_WIDTH(7)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .number(number2), .blank_lz(blank2), .done(done2), .sign_n(sign_n2),
        .bcd(bcd2), .segments(segments2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one word on the 8-bit instance and return cycles from acceptance to done.
    task automatic conv8(input logic [7:0] n, input logic b, output int lat);
        @(negedge clk);
        number   = n;
        blank_lz = b;
        in_valid = 1'b1;
        check("rdy_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        number   = ~n;
        blank_lz = ~b;
        check("rdy_busy", 64'(in_ready), 64'd0);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("done_seen", 64'(lat > 0), 64'd1);
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
        check("rdy_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int dones;
        int first_done;
        int second_done;
        logic [11:0] bcd_hold;

        #12;
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_seg", 64'(segments), 64'd0);
        check("rst_sign", 64'(sign_n), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_bcd", 64'(bcd), 64'd0);
        check("idle_seg", 64'(segments), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_rdy", 64'(in_ready), 64'd1);

        conv8(8'h7F, 1'b0, lat);
        check("7f_lat", 64'(lat), 64'd9);
        check("7f_bcd", 64'(bcd), 64'h127);
        check("7f_seg", 64'(segments), 64'({7'h06, 7'h5B, 7'h07}));
        check("7f_sign", 64'(sign_n), 64'd1);

        bcd_hold = bcd;
        repeat (6) @(negedge clk);
        check("hold_bcd", 64'(bcd), 64'(bcd_hold));
        check("hold_seg", 64'(segments), 64'({7'h06, 7'h5B, 7'h07}));

        conv8(8'h80, 1'b0, lat);
        check("80_lat", 64'(lat), 64'd9);
        check("80_bcd", 64'(bcd), 64'h128);
        check("80_seg", 64'(segments), 64'({7'h06, 7'h5B, 7'h7F}));
        check("80_sign", 64'(sign_n), 64'd0);

        conv8(8'hFF, 1'b1, lat);
        check("ff_bcd", 64'(bcd), 64'h001);
        check("ff_seg", 64'(segments), 64'({7'h00, 7'h00, 7'h06}));
        check("ff_sign", 64'(sign_n), 64'd0);

        conv8(8'h00, 1'b0, lat);
        check("00_bcd", 64'(bcd), 64'h000);
        check("00_seg", 64'(segments), 64'({7'h3F, 7'h3F, 7'h3F}));
        check("00_sign", 64'(sign_n), 64'd1);

        conv8(8'h00, 1'b1, lat);
        check("00b_seg", 64'(segments), 64'({7'h00, 7'h00, 7'h3F}));
        check("00b_sign", 64'(sign_n), 64'd1);

        conv8(8'h9C, 1'b1, lat);
        check("m100_bcd", 64'(bcd), 64'h100);
        check("m100_seg", 64'(segments), 64'({7'h06, 7'h3F, 7'h3F}));
        check("m100_sign", 64'(sign_n), 64'd0);

        conv8(8'hF6, 1'b1, lat);
        check("m10_bcd", 64'(bcd), 64'h010);
        check("m10_seg", 64'(segments), 64'({7'h00, 7'h06, 7'h3F}));

        conv8(8'h2D, 1'b0, lat);
        check("45_bcd", 64'(bcd), 64'h045);
        check("45_seg", 64'(segments), 64'({7'h3F, 7'h66, 7'h6D}));
        check("45_sign", 64'(sign_n), 64'd1);

        // in_valid held high; number churns while busy, 0x42 presented when the first result lands.
        @(negedge clk);
        number   = 8'h05;
        blank_lz = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i <= 30; i++) begin
            @(negedge clk);
            check("hs_rdy", 64'(in_ready), 64'(i == 9 || i == 19));
            if (done && first_done < 0) begin
                first_done = i;
                check("hs_bcd1", 64'(bcd), 64'h005);
                number = 8'h42;
            end else if (done) begin
                second_done = i;
                check("hs_bcd2", 64'(bcd), 64'h066);
                in_valid = 1'b0;
                break;
            end else begin
                number = 8'h30 + 8'(i);
            end
        end
        in_valid = 1'b0;
        check("hs_done1", 64'(first_done), 64'd9);
        check("hs_done2", 64'(second_done), 64'd19);

        conv8(8'h80, 1'b0, lat);
        @(negedge clk);
        number   = 8'h7F;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mr_bcd", 64'(bcd), 64'd0);
        check("mr_seg", 64'(segments), 64'd0);
        check("mr_sign", 64'(sign_n), 64'd1);
        check("mr_done", 64'(done), 64'd0);
        check("mr_rdy", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mr_nodone", 64'(dones), 64'd0);
        check("mr_bcd_hold", 64'(bcd), 64'd0);

        @(negedge clk);
        number2   = 16'h8000;
        blank2    = 1'b0;
        in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done2) begin
                lat = i;
                break;
            end
        end
        check("w16_lat", 64'(lat), 64'd17);
        check("w16_bcd", 64'(bcd2), 64'h32768);
        check("w16_seg", 64'(segments2), 64'({7'h4F, 7'h5B, 7'h07, 7'h7D, 7'h7F}));
        check("w16_sign", 64'(sign_n2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/seq_c2_bcd_display_decoder.md
# seq_c2_bcd_display_decoder

Sequential, parametrised successor to the combinational two's-complement-to-seven-segment decoder. It accepts a signed DW_IN-bit word through a valid/ready handshake and converts its magnitude to DIGITS BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It then registers the BCD digits, per-digit seven-segment patterns and an active-low sign output. Optional leading-zero blanking is included. It sits between the datapath producing signed results and the board's display drivers.

## Interface
- DW_IN, 8, input word width in bits (two's complement), ≥ 2
- DIGITS, 3, number of decimal digits produced; must be ≥ decimal digit count of 2^(DW_IN-1); elaboration error otherwise
- SEGMENT_WIDTH, 7, segments per digit; fixed at 7

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  number is valid this cycle
- in_ready  output  1  block can accept; high only in IDLE
- number  input  DW_IN  signed two's-complement value
- blank_lz  input  1  leading-zero blanking enable, sampled with number
- done  output  1  one-cycle pulse: new result registered
- sign_n  output  1  low = result negative
- bcd  output  4*DIGITS  BCD magnitude, digit 0 (units) in bits [3:0]
- segments  output  7*DIGITS  digit k pattern in bits [7k+6:7k], bit order {g,f,e,d,c,b,a}, 1 = lit

## Operation
- Asynchronous reset behaviour:
  - state = IDLE, so in_ready = 1.
  - done = 0, sign_n = 1, bcd = 0, segments = 0 (all blank).
  - Internal shift register and counter are cleared.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - in_ready = 1.
  - When in_valid is high, the handshake completes; this is the acceptance edge.
  - On acceptance:
    - Capture neg = number[DW_IN-1] and blank_lz.
    - Capture magnitude = neg ? (~number + 1) : number as a DW_IN-bit unsigned value, so the most negative input -2^(DW_IN-1) yields 2^(DW_IN-1) correctly.
    - Clear the BCD field and the bit counter, then go to SHIFT.
- SHIFT, one iteration per cycle for exactly DW_IN cycles:
  - Each BCD digit ≥ 5 has 3 added.
  - The concatenation {BCD, magnitude} is then shifted left by 1.
  - After the DW_IN-th shift, go to LOAD.
- LOAD, one cycle:
  - bcd is updated from the BCD field.
  - segments are updated through the digit decode.
  - sign_n = ~(neg & (magnitude != 0)).
  - done = 1 for exactly that next cycle; state returns to IDLE.
- Digit decode:
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F.
  - Codes 10–15 cannot occur; decode them to 0x00.
- Leading-zero blanking, when the captured blank_lz = 1:
  - Every zero digit above the most significant non-zero digit gets segments = 0.
  - The units digit is never blanked.
  - bcd is not affected by blanking.
- Not in IDLE:
  - in_ready = 0.
  - in_valid, number and blank_lz are ignored; changes to them do not affect the conversion in flight.
- Result outputs hold their value until the next LOAD.
- Reset asserted mid-conversion aborts immediately to reset values; no done pulse is produced.

## Timing
- Acceptance edge E0. Shifts occur on edges E1..E_DW_IN. Outputs and done register on edge E_DW_IN+1.
- Latency from acceptance to done high: DW_IN+1 cycles (9 for DW_IN = 8).
- in_ready is low from after E0 until after E_DW_IN+1.
- Next acceptance at E_DW_IN+2 at the earliest, giving a throughput of one conversion per DW_IN+2 cycles.
- done is never high for two consecutive cycles.
- in_ready is driven from state only, with no combinational path from in_valid.

## Test plan
- Reset, then idle:
  - bcd = 0, segments = 0, sign_n = 1, done = 0, in_ready = 1.
  - Outputs stay unchanged while in_valid = 0.
- DW_IN=8, number = 0x7F, blank_lz = 0:
  - done exactly 9 cycles after acceptance.
  - bcd = 0x127, segments = {0x06, 0x5B, 0x07}, sign_n = 1.
- number = 0x80:
  - bcd = 0x128, sign_n = 0.
- number = 0xFF, blank_lz = 1:
  - bcd = 0x001, segments = {0x00, 0x00, 0x06}, sign_n = 0.
- number = 0x00:
  - With blank_lz = 0: segments = {0x3F, 0x3F, 0x3F}, sign_n = 1.
  - With blank_lz = 1: segments = {0x00, 0x00, 0x3F}.
- Handshake and reset:
  - in_valid held high with number changing during SHIFT: only the first value is converted; in_ready = 0 throughout.
  - Second acceptance occurs at E10 at the earliest.
  - rst_n pulsed at E4 mid-conversion: reset values are restored and no done pulse occurs.
- DW_IN=16, DIGITS=5, number = 0x8000:
  - bcd = 0x32768, sign_n = 0, done 17 cycles after acceptance.
